mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of bus requesters (index 0 = video refresh, 1 = processor, 2 = DMA); range 2..8.
REQ-002 Parameter WAIT_CYCLES, default 1: extra memory wait states per access; range 0..15.
REQ-003 Parameter MAX_LOCK, default 4: maximum consecutive locked accesses by one owner while another requester is waiting; range 1..15.
REQ-004 Parameter HIPRI0, default 1: 1 = requester 0 has fixed priority over round-robin; 0 = requester 0 joins round-robin.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req  input  NREQ  per-requester access request, level.
REQ-008 lock  input  NREQ  per-requester bus-lock hint, sampled only for the current owner.
REQ-009 we  input  NREQ  per-requester write enable (1 = write, 0 = read).
REQ-010 addr  input  NREQ*16  flattened per-requester address, slice i = bits [16i+15:16i].
REQ-011 wdata  input  NREQ*8  flattened per-requester write data.
REQ-012 gnt  output  NREQ  one-hot grant, zero when no access is in flight.
REQ-013 ack  output  NREQ  one-cycle completion pulse to the owner.
REQ-014 rdata  output  8  read data, valid while ack is high; holds until the next read completes.
REQ-015 mem_addr  output  16  memory address.
REQ-016 mem_wdata  output  8  memory write data.
REQ-017 mem_rdata  input  8  memory read data.
REQ-018 mem_rd, mem_wr  output  1 each  memory strobes, mutually exclusive.

Function
REQ-019 FSM states: IDLE, ACCESS, DONE.
REQ-020 IDLE: when any req is high at a rising edge, select winner, set gnt one-hot, latch addr/wdata/we slices into mem_addr/mem_wdata/strobes, load wait counter with WAIT_CYCLES, go to ACCESS.
REQ-021 Selection: HIPRI0=1 and req[0] high -> requester 0; else first requesting index after the round-robin pointer, wrapping modulo NREQ.
REQ-022 Round-robin pointer updates to the winner index on every grant of a round-robin requester; it is unchanged by HIPRI0 grants.
REQ-023 ACCESS: decrement counter each edge; at the edge with counter == 0, capture mem_rdata into rdata if a read, drop mem_rd/mem_wr, assert ack[owner], go to DONE.
REQ-024 Latency: grant edge k -> ack high after edge k+1+WAIT_CYCLES; mem strobe high for exactly WAIT_CYCLES+1 cycles.
REQ-025 DONE lasts one cycle; gnt stays on owner; ack drops at the next edge.
REQ-026 At the DONE-exit edge: if req[owner] and lock[owner] are high and (lock count < MAX_LOCK or no other req is high), reissue to the same owner directly into ACCESS and increment lock count.
REQ-027 Otherwise at the DONE-exit edge, arbitrate per REQ-021 among current req and go to ACCESS; with no req, clear gnt and go to IDLE; lock count clears on any owner change.
REQ-028 A requester holding req high through DONE without lock is treated as a new request and competes normally.
REQ-029 req, addr, we and wdata changes during ACCESS are ignored; the access uses the values latched at grant.
REQ-030 Dropping req[owner] during ACCESS does not abort the access; ack is still pulsed.
REQ-031 mem_rd and mem_wr are never high together and are both low in IDLE and DONE.

Reset
REQ-032 Asserting reset at any time, including mid-access, forces IDLE immediately: gnt, ack, mem_rd, mem_wr = 0; mem_addr = 16'h0000; mem_wdata, rdata = 8'h00; wait and lock counters = 0; round-robin pointer = NREQ-1, so requester 0 wins the first round-robin tie.
REQ-033 An interrupted access produces no ack after reset releases; the requester reissues.

Structure
REQ-034 Package mem_bus_pkg holds the FSM state enum and the constants ADDR_W=16 and DATA_W=8.
REQ-035 Round-robin selection is a combinational sub-module bus_rr_picker(req, pointer -> one-hot winner, winner index).

Verification
REQ-036 WAIT_CYCLES=1, single read by req[1] at addr 16'h2000 with mem_rdata=8'hA5 -> mem_rd high 2 cycles, ack[1] after edge k+2, rdata=8'hA5.
REQ-037 req[1] and req[2] held high continuously, HIPRI0=0 -> grants alternate 1,2,1,2; never two consecutive grants to one index.
REQ-038 req[0] rises while req[2] is mid-access, HIPRI0=1 -> req[2] access completes with ack, then requester 0 granted before requester 1.
REQ-039 req[2] and lock[2] held high, req[1] high, MAX_LOCK=4 -> 1 normal + 4 locked accesses to 2, then grant to 1.
REQ-040 reset pulled low during ACCESS of a write to 16'h1F00 -> mem_wr, gnt and ack drop asynchronously; no ack after release.
REQ-041 WAIT_CYCLES=0, back-to-back writes 8'h11, 8'h22 by locked req[1] -> ack every 2 cycles, mem_wr never overlaps mem_rd.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the memory bus arbiter.
package mem_bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/bus_rr_picker.sv
// Round-robin requester picker: first requesting index after the pointer,
// wrapping modulo NREQ. Purely combinational.
module bus_rr_picker
    import mem_bus_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] pointer,
    output logic [NREQ-1:0]  winner,
    output logic [IDX_W-1:0] winner_idx
);

    logic found;
    int   cand;

    // Scan from pointer+1 around to the pointer itself; the first hit wins.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(pointer) + off) % NREQ;
            if (!found && req[IDX_W'(cand)]) begin
                found                = 1'b1;
                winner[IDX_W'(cand)] = 1'b1;
                winner_idx           = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: grants one of NREQ requesters a single memory access
// with fixed wait states, optional fixed priority for requester 0, round-robin
// for the rest, and bounded bus locking by the current owner.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_LOCK    = 4,
    parameter int HIPRI0      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        lock,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*DATA_W-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      rdata,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   mem_rd,
    output logic                   mem_wr
);

    localparam int               IDX_W     = $clog2(NREQ);
    localparam logic [3:0]       WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [3:0]       LOCK_MAX  = 4'(MAX_LOCK);
    localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(NREQ - 1);

    state_t           state;
    logic [3:0]       wait_cnt;
    logic [3:0]       lock_cnt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;

    logic [NREQ-1:0]  pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             hipri_win;
    logic             others_waiting;
    logic             reissue;
    logic             start;
    logic [IDX_W-1:0] start_idx;
    logic [NREQ-1:0]  start_onehot;

    bus_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (req),
        .pointer    (rr_ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx)
    );

    // Decide who gets the next access: a locked reissue to the current owner
    // beats arbitration; otherwise fixed-priority 0, then round-robin.
    always_comb begin
        hipri_win      = (HIPRI0 != 0) && req[0];
        others_waiting = |(req & ~gnt);
        reissue        = (state == DONE) && req[owner] && lock[owner] &&
                         ((lock_cnt < LOCK_MAX) || !others_waiting);
        start          = ((state == IDLE) || (state == DONE)) && (reissue || (|req));
        if (reissue) begin
            start_idx    = owner;
            start_onehot = gnt;
        end else if (hipri_win) begin
            start_idx    = '0;
            start_onehot = NREQ'(1);
        end else begin
            start_idx    = pick_idx;
            start_onehot = pick_onehot;
        end
    end

    // Arbiter FSM with registered grant, strobes, ack and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            wait_cnt  <= '0;
            lock_cnt  <= '0;
            rr_ptr    <= PTR_INIT;
            owner     <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= ACCESS;
                        gnt       <= start_onehot;
                        owner     <= start_idx;
                        mem_addr  <= addr[start_idx*ADDR_W +: ADDR_W];
                        mem_wdata <= wdata[start_idx*DATA_W +: DATA_W];
                        mem_rd    <= ~we[start_idx];
                        mem_wr    <= we[start_idx];
                        wait_cnt  <= WAIT_INIT;
                        if (reissue) begin
                            lock_cnt <= (lock_cnt == 4'hF) ? lock_cnt : lock_cnt + 4'd1;
                        end else begin
                            lock_cnt <= '0;
                            if (!hipri_win) begin
                                rr_ptr <= pick_idx;
                            end
                        end
                    end else begin
                        state    <= IDLE;
                        gnt      <= '0;
                        lock_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        if (mem_rd) begin
                            rdata <= mem_rdata;
                        end
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        ack    <= gnt;
                        state  <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: one instance with WAIT_CYCLES=1/HIPRI0=1 and
// one with WAIT_CYCLES=0/HIPRI0=0 share the stimulus; each check targets one.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req, lock, we;
    logic [47:0] addr;
    logic [23:0] wdata;
    logic [7:0]  mem_rdata;

    logic [2:0]  gnt_a, ack_a, gnt_b, ack_b;
    logic [7:0]  rdata_a, rdata_b, mwd_a, mwd_b;
    logic [15:0] maddr_a, maddr_b;
    logic        mrd_a, mwr_a, mrd_b, mwr_b;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.NREQ(3), .WAIT_CYCLES(1), .MAX_LOCK(4), .HIPRI0(1)) dut_a (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt_a), .ack(ack_a), .rdata(rdata_a),
        .mem_addr(maddr_a), .mem_wdata(mwd_a), .mem_rdata(mem_rdata),
        .mem_rd(mrd_a), .mem_wr(mwr_a)
    );

    mem_bus_arbiter #(.NREQ(3), .WAIT_CYCLES(0), .MAX_LOCK(4), .HIPRI0(0)) dut_b (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt_b), .ack(ack_b), .rdata(rdata_b),
        .mem_addr(maddr_b), .mem_wdata(mwd_b), .mem_rdata(mem_rdata),
        .mem_rd(mrd_b), .mem_wr(mwr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  lock;
        logic [2:0]  we;
        logic [7:0]  mrd;
        logic [2:0]  gnt;
        logic [2:0]  ack;
        logic        rd;
        logic        wr;
        logic [7:0]  rdata;
        logic [15:0] maddr;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] exp_lock[6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b010};
        logic [2:0] exp_rr[6]   = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100};
        logic [2:0] acc;
        logic       overlap;
        int         n;

        // slice 2 = 16'h1F00, slice 1 = 16'h2000, slice 0 = 16'h1000
        tbl[0]  = '{3'b010, 3'b000, 3'b000, 8'h00, 3'b010, 3'b000, 1'b1, 1'b0, 8'h00, 16'h2000};
        tbl[1]  = '{3'b000, 3'b000, 3'b000, 8'h00, 3'b010, 3'b000, 1'b1, 1'b0, 8'h00, 16'h2000};
        tbl[2]  = '{3'b000, 3'b000, 3'b000, 8'hA5, 3'b010, 3'b010, 1'b0, 1'b0, 8'hA5, 16'h2000};
        tbl[3]  = '{3'b000, 3'b000, 3'b000, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 8'hA5, 16'h2000};
        tbl[4]  = '{3'b100, 3'b000, 3'b100, 8'h00, 3'b100, 3'b000, 1'b0, 1'b1, 8'hA5, 16'h1F00};
        tbl[5]  = '{3'b111, 3'b000, 3'b100, 8'h00, 3'b100, 3'b000, 1'b0, 1'b1, 8'hA5, 16'h1F00};
        tbl[6]  = '{3'b011, 3'b000, 3'b100, 8'h00, 3'b100, 3'b100, 1'b0, 1'b0, 8'hA5, 16'h1F00};
        tbl[7]  = '{3'b011, 3'b000, 3'b000, 8'h00, 3'b001, 3'b000, 1'b1, 1'b0, 8'hA5, 16'h1000};
        tbl[8]  = '{3'b010, 3'b000, 3'b000, 8'h00, 3'b001, 3'b000, 1'b1, 1'b0, 8'hA5, 16'h1000};
        tbl[9]  = '{3'b010, 3'b000, 3'b000, 8'h5A, 3'b001, 3'b001, 1'b0, 1'b0, 8'h5A, 16'h1000};
        tbl[10] = '{3'b010, 3'b000, 3'b000, 8'h00, 3'b010, 3'b000, 1'b1, 1'b0, 8'h5A, 16'h2000};
        tbl[11] = '{3'b000, 3'b000, 3'b000, 8'h00, 3'b010, 3'b000, 1'b1, 1'b0, 8'h5A, 16'h2000};
        tbl[12] = '{3'b000, 3'b000, 3'b000, 8'h3C, 3'b010, 3'b010, 1'b0, 1'b0, 8'h3C, 16'h2000};
        tbl[13] = '{3'b000, 3'b000, 3'b000, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 8'h3C, 16'h2000};

        reset     = 1'b0;
        req       = '0;
        lock      = '0;
        we        = '0;
        addr      = {16'h1F00, 16'h2000, 16'h1000};
        wdata     = {8'h33, 8'h11, 8'h00};
        mem_rdata = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt_a",   32'(gnt_a), 32'h0);
        chk("rst_ack_a",   32'(ack_a), 32'h0);
        chk("rst_strb_a",  32'({mrd_a, mwr_a}), 32'h0);
        chk("rst_maddr_a", 32'(maddr_a), 32'h0);
        chk("rst_mwd_a",   32'(mwd_a), 32'h0);
        chk("rst_rdata_a", 32'(rdata_a), 32'h0);
        chk("rst_gnt_b",   32'(gnt_b), 32'h0);
        chk("rst_strb_b",  32'({mrd_b, mwr_b}), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Table: single read, write then fixed-priority 0 ahead of 1, round-robin
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req       = tbl[i].req;
            lock      = tbl[i].lock;
            we        = tbl[i].we;
            mem_rdata = tbl[i].mrd;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_gnt", i),   32'(gnt_a), 32'(tbl[i].gnt));
            chk($sformatf("row%0d_ack", i),   32'(ack_a), 32'(tbl[i].ack));
            chk($sformatf("row%0d_strb", i),  32'({mrd_a, mwr_a}), 32'({tbl[i].rd, tbl[i].wr}));
            chk($sformatf("row%0d_rdata", i), 32'(rdata_a), 32'(tbl[i].rdata));
            chk($sformatf("row%0d_maddr", i), 32'(maddr_a), 32'(tbl[i].maddr));
        end

        // Lock limit: 1 normal + 4 locked accesses to 2, then requester 1
        @(negedge clk);
        req  = 3'b110;
        lock = 3'b100;
        we   = 3'b100;
        n    = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(posedge clk);
            #1;
            if (ack_a != 3'b000) begin
                chk($sformatf("lock_ack%0d", n), 32'(ack_a), 32'(exp_lock[n]));
                n++;
            end
        end
        if (n < 6) chk("lock_timeout", 32'(n), 32'd6);
        @(negedge clk);
        req  = '0;
        lock = '0;
        we   = '0;
        repeat (3) @(posedge clk);

        // Asynchronous reset in the middle of a write to 16'h1F00
        do_reset();
        @(negedge clk);
        req = 3'b100;
        we  = 3'b100;
        @(posedge clk);
        #1;
        chk("arst_pre_gnt",   32'(gnt_a), 32'h4);
        chk("arst_pre_wr",    32'(mwr_a), 32'h1);
        chk("arst_pre_maddr", 32'(maddr_a), 32'h1F00);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_gnt",   32'(gnt_a), 32'h0);
        chk("arst_wr",    32'(mwr_a), 32'h0);
        chk("arst_ack",   32'(ack_a), 32'h0);
        chk("arst_maddr", 32'(maddr_a), 32'h0);
        @(negedge clk);
        req = '0;
        we  = '0;
        @(negedge clk);
        reset = 1'b1;
        acc = '0;
        repeat (6) begin
            @(posedge clk);
            #1;
            acc = acc | ack_a;
        end
        chk("arst_no_ack", 32'(acc), 32'h0);
        chk("arst_idle_gnt", 32'(gnt_a), 32'h0);

        // Round-robin alternation between requesters 1 and 2 (instance b)
        @(negedge clk);
        req = 3'b110;
        n   = 0;
        for (int c = 0; c < 30 && n < 6; c++) begin
            @(posedge clk);
            #1;
            if (ack_b != 3'b000) begin
                chk($sformatf("rr_ack%0d", n), 32'(ack_b), 32'(exp_rr[n]));
                n++;
            end
        end
        if (n < 6) chk("rr_timeout", 32'(n), 32'd6);
        @(negedge clk);
        req = '0;
        repeat (3) @(posedge clk);

        // Back-to-back locked writes with zero wait states (instance b)
        @(negedge clk);
        req   = 3'b010;
        lock  = 3'b010;
        we    = 3'b010;
        wdata = {8'h33, 8'h11, 8'h00};
        @(posedge clk);
        #1;
        overlap = mrd_b & mwr_b;
        chk("b2b_g1_ack", 32'(ack_b), 32'h0);
        chk("b2b_g1_wr",  32'(mwr_b), 32'h1);
        chk("b2b_g1_wd",  32'(mwd_b), 32'h11);
        @(negedge clk);
        wdata = {8'h33, 8'h22, 8'h00};
        @(posedge clk);
        #1;
        overlap = overlap | (mrd_b & mwr_b);
        chk("b2b_a1_ack", 32'(ack_b), 32'h2);
        chk("b2b_a1_wr",  32'(mwr_b), 32'h0);
        @(posedge clk);
        #1;
        overlap = overlap | (mrd_b & mwr_b);
        chk("b2b_g2_ack", 32'(ack_b), 32'h0);
        chk("b2b_g2_wr",  32'(mwr_b), 32'h1);
        chk("b2b_g2_wd",  32'(mwd_b), 32'h22);
        @(negedge clk);
        req  = '0;
        lock = '0;
        we   = '0;
        @(posedge clk);
        #1;
        overlap = overlap | (mrd_b & mwr_b);
        chk("b2b_a2_ack", 32'(ack_b), 32'h2);
        chk("b2b_a2_wr",  32'(mwr_b), 32'h0);
        @(posedge clk);
        #1;
        chk("b2b_idle_gnt", 32'(gnt_b), 32'h0);
        chk("b2b_overlap",  32'(overlap), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
